mem_arb: RTL and testbench

Shared memory-port arbiter for the hart. It merges three line-granular requesters onto one external memory port: L1i refill (imem), L1d refill (dmem) and L1d write-back (dmem). It sits between the caches' `b_*` buses and the system memory interface. It serialises transactions with a registered FSM, applies D-over-I priority with an anti-starvation alternation rule, and flags memory that never acknowledges.

---
 rtl/mem_arb.sv | 148 ++++++++++++++
 tb/tb_mem_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: serialises L1i refills, L1d refills and L1d write-backs onto one
// line-granular memory port. Write-back has priority; I/D refill contention
// alternates on the last D grant. A watchdog flags memory that never acks.
module mem_arb #(
    parameter int LINE_W  = 1024,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic [LINE_W-1:0] i_data,
    output logic              i_dv,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_dv,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              err
);

    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_I = 3'd1,
        RD_D = 3'd2,
        WR_D = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_d_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy;
    logic              grant;
    logic              wd_fire;
    logic              m_rd_d;
    logic              m_wr_d;
    logic              i_dv_d;
    logic              d_dv_d;

    // Clear the byte-offset bits so the memory always sees a line address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~LOW_MASK;
    endfunction

    assign busy    = (state_q == RD_I) || (state_q == RD_D) || (state_q == WR_D);
    assign grant   = (state_q == IDLE) && (state_d != IDLE);
    // Fires in the TIMEOUT-th busy cycle; a simultaneous ack takes precedence.
    assign wd_fire = (TIMEOUT != 0) && busy && !m_ack && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: grant selection in IDLE, completion on ack or watchdog.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_wr)              state_d = WR_D;
                else if (d_rd && i_rd) state_d = last_d_q ? RD_I : RD_D;
                else if (d_rd)         state_d = RD_D;
                else if (i_rd)         state_d = RD_I;
            end
            RD_I, RD_D, WR_D: begin
                if (m_ack || wd_fire) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the strobes and pulses are registered.
    always_comb begin
        m_rd_d = (state_d == RD_I) || (state_d == RD_D);
        m_wr_d = (state_d == WR_D);
        i_dv_d = (state_d == DONE) && !last_d_q;
        d_dv_d = (state_d == DONE) && last_d_q;
    end

    // Registered strobes and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd <= 1'b0;
            m_wr <= 1'b0;
            i_dv <= 1'b0;
            d_dv <= 1'b0;
        end else begin
            m_rd <= m_rd_d;
            m_wr <= m_wr_d;
            i_dv <= i_dv_d;
            d_dv <= d_dv_d;
        end
    end

    // Latch address, write data and the owner of the transaction at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr   <= '0;
            m_wdata  <= '0;
            last_d_q <= 1'b0;
        end else if (grant) begin
            m_addr   <= line_align((state_d == RD_I) ? i_addr : d_addr);
            last_d_q <= (state_d != RD_I);
            if (state_d == WR_D) m_wdata <= d_wdata;
        end
    end

    // Capture the returned line for the requester that owns the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_data  <= '0;
            d_rdata <= '0;
        end else if (m_ack) begin
            if (state_q == RD_I) i_data  <= m_rdata;
            if (state_q == RD_D) d_rdata <= m_rdata;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err   <= 1'b0;
        end else begin
            if (grant)     cnt_q <= '0;
            else if (busy) cnt_q <= cnt_q + 1'b1;
            if (wd_fire)   err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed and randomized bench for mem_arb. The bench plays the
// requesters and the memory, and predicts grants, data and flags with a
// request-level model of the arbitration rules.
module tb_mem_arb;

    localparam int LW = 1024;
    localparam int AW = 64;
    localparam int TO = 8;
    localparam int LB = LW / 8;

    localparam int G_NONE = 0;
    localparam int G_I    = 1;
    localparam int G_D    = 2;
    localparam int G_W    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_addr;
    logic          i_rd;
    logic [LW-1:0] i_data;
    logic          i_dv;
    logic [AW-1:0] d_addr;
    logic          d_rd;
    logic          d_wr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_dv;
    logic [AW-1:0] m_addr;
    logic          m_rd;
    logic          m_wr;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_rdata;
    logic          m_ack;
    logic          err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int d_dv_cnt = 0;

    // Model state: who won the last grant, the sticky error, the expected lines.
    bit            md_last_d;
    bit            md_err;
    logic [LW-1:0] md_idata;
    logic [LW-1:0] md_ddata;

    mem_arb #(.LINE_W(LW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_dv(d_dv),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (d_dv === 1'b1) d_dv_cnt <= d_dv_cnt + 1;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[95:0], exp[95:0]);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    // Arbitration rule: write-back first, then refills, alternating on conflict.
    function automatic int pick(bit wr, bit dr, bit ir, bit last_d);
        if (wr)       return G_W;
        if (dr && ir) return last_d ? G_I : G_D;
        if (dr)       return G_D;
        if (ir)       return G_I;
        return G_NONE;
    endfunction

    task automatic clr_req(input int g);
        if (g == G_I) i_rd = 1'b0;
        if (g == G_D) d_rd = 1'b0;
        if (g == G_W) d_wr = 1'b0;
    endtask

    // One transaction, entered at a negedge in IDLE with requests already driven.
    // Ends at the negedge of the IDLE cycle that follows the dv pulse.
    task automatic run_txn(input int lat, input bit drop, input bit drop_early,
                           input bit tmo, output int g, output int dv_cyc);
        logic [AW-1:0] ea;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        logic [LW-1:0] rd;
        logic [1:0]    strobe;
        int            n;
        g      = pick(d_wr, d_rd, i_rd, md_last_d);
        a      = (g == G_I) ? i_addr : d_addr;
        ea     = (a / LB) * LB;
        wd     = d_wdata;
        rd     = rand_line();
        strobe = (g == G_W) ? 2'b01 : 2'b10;
        n      = tmo ? TO : lat;
        @(negedge clk);
        chk("strobe_rise", {m_rd, m_wr}, strobe);
        chk("m_addr", m_addr, ea);
        if (g == G_W) chk("m_wdata", m_wdata, wd);
        if (drop_early) clr_req(g);
        for (int j = 1; j <= n; j++) begin
            if (j > 1) @(negedge clk);
            chk("strobe_hold", {m_rd, m_wr}, strobe);
            chk("dv_quiet", {i_dv, d_dv}, 2'b00);
            if (!tmo && j == n) begin
                m_ack   = 1'b1;
                m_rdata = rd;
            end
        end
        @(negedge clk);
        m_ack   = 1'b0;
        m_rdata = rand_line();
        if (tmo)            md_err   = 1'b1;
        else if (g == G_I)  md_idata = rd;
        else if (g == G_D)  md_ddata = rd;
        md_last_d = (g != G_I);
        chk("strobe_fall", {m_rd, m_wr}, 2'b00);
        chk("i_dv", i_dv, g == G_I);
        chk("d_dv", d_dv, g != G_I);
        chk("i_data", i_data, md_idata);
        chk("d_rdata", d_rdata, md_ddata);
        chk("err", err, md_err);
        dv_cyc = cyc;
        if (drop) clr_req(g);
        @(negedge clk);
        chk("idle_strobe", {m_rd, m_wr}, 2'b00);
        chk("idle_dv", {i_dv, d_dv}, 2'b00);
    endtask

    initial begin
        int g;
        int dvc;
        int prev_dvc;
        int cnt0;
        int r;

        rst_n   = 1'b0;
        i_addr  = '0;
        i_rd    = 1'b0;
        d_addr  = '0;
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        d_wdata = '0;
        m_rdata = '0;
        m_ack   = 1'b0;
        md_last_d = 1'b0;
        md_err    = 1'b0;
        md_idata  = '0;
        md_ddata  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_strobes", {m_rd, m_wr}, 2'b00);
        chk("rst_dv", {i_dv, d_dv}, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_i_data", i_data, '0);
        chk("rst_d_rdata", d_rdata, '0);
        chk("rst_m_addr", m_addr, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single I refill, 4-cycle memory latency
        i_rd   = 1'b1;
        i_addr = 64'h1234;
        run_txn(4, 1'b1, 1'b0, 1'b0, g, dvc);
        chk("single_m_addr_model", m_addr, 64'h1200);

        // Spurious ack in IDLE
        m_ack   = 1'b1;
        m_rdata = rand_line();
        @(negedge clk);
        m_ack = 1'b0;
        chk("spur_dv", {i_dv, d_dv}, 2'b00);
        chk("spur_strobe", {m_rd, m_wr}, 2'b00);
        chk("spur_i_data", i_data, md_idata);
        @(negedge clk);
        chk("spur_dv2", {i_dv, d_dv}, 2'b00);
        chk("spur_d_rdata", d_rdata, md_ddata);

        // Alternation with both refills held and immediate acks
        i_addr = rand_addr();
        d_addr = i_addr ^ 64'h400;
        i_rd   = 1'b1;
        d_rd   = 1'b1;
        prev_dvc = 0;
        for (int k = 0; k < 4; k++) begin
            run_txn(1, 1'b0, 1'b0, 1'b0, g, dvc);
            chk("alt_grant", g, (k % 2 == 0) ? G_D : G_I);
            if (k > 0) chk("alt_spacing", dvc - prev_dvc, 3);
            prev_dvc = dvc;
        end
        i_rd = 1'b0;
        d_rd = 1'b0;

        // Write-back and refill together
        cnt0    = d_dv_cnt;
        d_addr  = rand_addr();
        d_wdata = rand_line();
        d_wr    = 1'b1;
        d_rd    = 1'b1;
        run_txn($urandom_range(1, 6), 1'b1, 1'b0, 1'b0, g, dvc);
        chk("wb_first", g, G_W);
        run_txn($urandom_range(1, 6), 1'b1, 1'b0, 1'b0, g, dvc);
        chk("refill_second", g, G_D);
        @(negedge clk);
        chk("wb_refill_dv_count", d_dv_cnt - cnt0, 2);

        // Randomized request mix
        for (int it = 0; it < 24; it++) begin
            r = $urandom_range(0, 7);
            if (!i_rd && r[0]) begin
                i_rd   = 1'b1;
                i_addr = rand_addr();
            end
            if (!d_rd && !d_wr && r[1]) d_addr = rand_addr();
            if (!d_rd && r[1]) d_rd = 1'b1;
            if (!d_wr && r[2]) begin
                if (!d_rd) d_addr = rand_addr();
                d_wr    = 1'b1;
                d_wdata = rand_line();
            end
            if (!i_rd && !d_rd && !d_wr) begin
                i_rd   = 1'b1;
                i_addr = rand_addr();
            end
            run_txn($urandom_range(1, TO - 1), 1'b1, ($urandom_range(0, 3) == 0), 1'b0, g, dvc);
        end
        i_rd = 1'b0;
        d_rd = 1'b0;
        d_wr = 1'b0;
        @(negedge clk);

        // Memory never acks: watchdog completes the read and raises err
        d_addr = rand_addr();
        d_rd   = 1'b1;
        run_txn(0, 1'b1, 1'b0, 1'b1, g, dvc);
        for (int k = 0; k < 2; k++) begin
            i_addr = rand_addr();
            i_rd   = 1'b1;
            run_txn($urandom_range(1, 5), 1'b1, 1'b0, 1'b0, g, dvc);
        end
        chk("err_sticky", err, 1'b1);

        // Asynchronous reset while a read is outstanding
        d_addr = rand_addr();
        d_rd   = 1'b1;
        @(negedge clk);
        chk("pre_rst_m_rd", m_rd, 1'b1);
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        m_ack   = 1'b1;
        m_rdata = rand_line();
        #1;
        md_err    = 1'b0;
        md_last_d = 1'b0;
        md_idata  = '0;
        md_ddata  = '0;
        chk("arst_strobes", {m_rd, m_wr}, 2'b00);
        chk("arst_err", err, 1'b0);
        chk("arst_dv", {i_dv, d_dv}, 2'b00);
        chk("arst_i_data", i_data, '0);
        chk("arst_d_rdata", d_rdata, '0);
        chk("arst_m_addr", m_addr, '0);
        chk("arst_m_wdata", m_wdata, '0);
        d_rd = 1'b0;
        repeat (2) @(negedge clk);
        chk("in_rst_dv", {i_dv, d_dv}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk("post_rst_dv", {i_dv, d_dv}, 2'b00);
        chk("post_rst_strobes", {m_rd, m_wr}, 2'b00);
        chk("post_rst_d_rdata", d_rdata, '0);
        @(negedge clk);
        chk("post_rst_dv2", {i_dv, d_dv}, 2'b00);

        // Fresh arbitration after reset: D wins the first conflict
        i_addr = rand_addr();
        d_addr = i_addr ^ 64'h800;
        i_rd   = 1'b1;
        d_rd   = 1'b1;
        run_txn(2, 1'b1, 1'b0, 1'b0, g, dvc);
        chk("post_rst_first", g, G_D);
        run_txn(3, 1'b1, 1'b0, 1'b0, g, dvc);
        chk("post_rst_second", g, G_I);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
